// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and source-register decode
// helpers for the hazard_ctrl pipeline sequencer.
package hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

    function automatic logic reads_rs1(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational load-use and taken-branch detection from the decode and
// execute instruction registers.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] IR_dc,
    input  logic        v_dc,
    input  logic [31:0] IR_ex,
    input  logic        v_ex,
    input  logic        CP_ex,
    output logic        lu,
    output logic        br
);

    logic [6:0] dc_op;
    logic [6:0] ex_op;
    logic [4:0] dc_rs1;
    logic [4:0] dc_rs2;
    logic [4:0] ex_rd;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_ir;

    assign dc_op  = IR_dc[6:0];
    assign dc_rs1 = IR_dc[19:15];
    assign dc_rs2 = IR_dc[24:20];
    assign ex_op  = IR_ex[6:0];
    assign ex_rd  = IR_ex[11:7];

    // Only count a match on a field the decode-stage format really reads.
    assign rs1_hit = reads_rs1(dc_op) && (dc_rs1 == ex_rd);
    assign rs2_hit = reads_rs2(dc_op) && (dc_rs2 == ex_rd);

    assign lu = v_ex && v_dc && (ex_op == OPC_LOAD) && (ex_rd != 5'd0) &&
                (rs1_hit || rs2_hit);
    assign br = v_ex && CP_ex;

    assign unused_ir = ^{IR_dc[31:25], IR_dc[14:7], IR_ex[31:12]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and, when
// HAZARD_CTRL_DEBUG_EN is defined, the debug halt/drain/single-step FSM.
//   state  | meaning
//   RUN    | normal execution, hazard logic only
//   DRAIN  | fetch stalled while in-flight instructions retire
//   HALTED | every stage frozen, halted asserted
//   STEP   | one clock of RUN behaviour, then back to HALTED
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            IR_dc,
    input  logic                   v_dc,
    input  logic [31:0]            IR_ex,
    input  logic                   v_ex,
    input  logic                   CP_ex,
    input  logic                   halt_req,
    input  logic                   step_req,
    output logic                   s_fe,
    output logic                   s_dc,
    output logic                   s_ex,
    output logic                   s_me,
    output logic                   s_wb,
    output logic                   fl_dc,
    output logic                   fl_ex,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic   lu;
    logic   br;
    logic   lu_eff;
    logic   any_stall;
    state_e state_q;

    logic [STALL_CNT_W-1:0] stall_cnt_q;

    hazard_detect u_detect (
        .IR_dc (IR_dc),
        .v_dc  (v_dc),
        .IR_ex (IR_ex),
        .v_ex  (v_ex),
        .CP_ex (CP_ex),
        .lu    (lu),
        .br    (br)
    );

    // A taken branch flushes the dependent instruction, so no bubble is needed.
    assign lu_eff = lu && !br;

`ifdef HAZARD_CTRL_DEBUG_EN
    localparam int unsigned     CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e             state_d;
    logic [CNT_W-1:0]   drain_q;
    logic [CNT_W-1:0]   drain_d;
    logic               halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                // A load-use bubble holds the drain count for that cycle.
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (!lu_eff) begin
                    if (drain_q == '0) state_d = ST_HALTED;
                    else               drain_d = drain_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_req)     state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP:  state_d = ST_HALTED;
            default:  state_d = ST_RUN;
        endcase
    end

    assign halted = halted_q;
`else
    logic unused_dbg;

    assign state_q    = ST_RUN;
    assign halted     = 1'b0;
    assign unused_dbg = halt_req ^ step_req;
`endif

    always_comb begin
        s_fe  = 1'b0;
        s_dc  = 1'b0;
        s_ex  = 1'b0;
        s_me  = 1'b0;
        s_wb  = 1'b0;
        fl_dc = 1'b0;
        fl_ex = 1'b0;
        if (rst) begin
            fl_dc = 1'b1;
            fl_ex = 1'b1;
        end else if (state_q == ST_HALTED) begin
            s_fe = 1'b1;
            s_dc = 1'b1;
            s_ex = 1'b1;
            s_me = 1'b1;
            s_wb = 1'b1;
        end else begin
            s_fe  = lu_eff || (state_q == ST_DRAIN);
            s_dc  = lu_eff;
            fl_dc = br;
            fl_ex = br || lu_eff;
        end
    end

    assign any_stall = s_fe || s_dc || s_ex || s_me || s_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (any_stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed load-use/branch/debug steps
// plus randomized instruction pairs checked against a register-set model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR_dc;
    logic        v_dc;
    logic [31:0] IR_ex;
    logic        v_ex;
    logic        CP_ex;
    logic        halt_req;
    logic        step_req;
    logic        s_fe, s_dc, s_ex, s_me, s_wb;
    logic        fl_dc, fl_ex;
    logic        halted;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.DRAIN_CYCLES(4), .STALL_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .IR_dc     (IR_dc),
        .v_dc      (v_dc),
        .IR_ex     (IR_ex),
        .v_ex      (v_ex),
        .CP_ex     (CP_ex),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .s_fe      (s_fe),
        .s_dc      (s_dc),
        .s_ex      (s_ex),
        .s_me      (s_me),
        .s_wb      (s_wb),
        .fl_dc     (fl_dc),
        .fl_ex     (fl_ex),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd);
        return {20'd1, rd, 7'h37};
    endfunction

    // Set of architectural registers an instruction reads, as a bit mask.
    function automatic logic [31:0] read_set(input logic [31:0] ir);
        logic [31:0] m;
        logic [6:0]  op;
        m  = '0;
        op = ir[6:0];
        if (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) m[ir[19:15]] = 1'b1;
        if (op inside {7'h33, 7'h23, 7'h63})                      m[ir[24:20]] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [8];
        logic [31:0] ir;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h6F};
        ir = $urandom;
        ir[6:0]   = ops[$urandom_range(0, 7)];
        ir[11:7]  = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        return ir;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic r,
                       input logic [31:0] idc, input logic vdc,
                       input logic [31:0] iex, input logic vex, input logic cp,
                       input logic hreq, input logic sreq,
                       input logic [4:0] es, input logic [1:0] ef, input logic eh);
        rst = r; IR_dc = idc; v_dc = vdc; IR_ex = iex; v_ex = vex; CP_ex = cp;
        halt_req = hreq; step_req = sreq;
        #2;
        chk({tag, " stalls"}, 64'({s_fe, s_dc, s_ex, s_me, s_wb}), 64'(es));
        chk({tag, " flush"}, 64'({fl_dc, fl_ex}), 64'(ef));
        chk({tag, " halted"}, 64'(halted), 64'(eh));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(exp_cnt));
        if (r) exp_cnt = 0;
        else if (es != 5'd0 && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] LW5, ADD6, LUI5, LW0, NOP, rdc, rex;
        logic        rvdc, rvex, rcp, lum, brm, lue, rh, rs;
        LW5  = enc_lw(5'd5, 5'd1);
        ADD6 = enc_r(5'd6, 5'd5, 5'd2);
        LUI5 = enc_lui(5'd5);
        LW0  = enc_lw(5'd0, 5'd1);
        NOP  = 32'h0000_0013;

        rst = 1'b1; IR_dc = NOP; v_dc = 1'b0; IR_ex = NOP; v_ex = 1'b0;
        CP_ex = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst stalls", 64'({s_fe, s_dc, s_ex, s_me, s_wb}), 64'd0);
        chk("rst flush", 64'({fl_dc, fl_ex}), 64'b11);
        chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);

        // Load-use: one bubble, then released.
        cyc("lu",      0, ADD6, 1, LW5, 1, 0, 0, 0, 5'b11000, 2'b01, 0);
        cyc("lu_next", 0, enc_r(5'd7, 5'd6, 5'd6), 1, ADD6, 1, 0, 0, 0, 5'b00000, 2'b00, 0);
        cyc("lui",     0, LUI5, 1, LW5, 1, 0, 0, 0, 5'b00000, 2'b00, 0);
        cyc("ld_x0",   0, enc_r(5'd6, 5'd0, 5'd0), 1, LW0, 1, 0, 0, 0, 5'b00000, 2'b00, 0);
        cyc("dc_inv",  0, ADD6, 0, LW5, 1, 0, 0, 0, 5'b00000, 2'b00, 0);
        cyc("rs2_hit", 0, enc_r(5'd6, 5'd2, 5'd5), 1, LW5, 1, 0, 0, 0, 5'b11000, 2'b01, 0);
        cyc("br_pri",  0, ADD6, 1, LW5, 1, 1, 0, 0, 5'b00000, 2'b11, 0);
        cyc("br_inv",  0, ADD6, 1, NOP, 0, 1, 0, 0, 5'b00000, 2'b00, 0);

        // Randomized instruction pairs against the register-set model.
        for (int i = 0; i < 300; i++) begin
            rdc  = rand_ir();
            rex  = rand_ir();
            rvdc = 1'($urandom_range(0, 7) != 0);
            rvex = 1'($urandom_range(0, 7) != 0);
            rcp  = 1'($urandom_range(0, 5) == 0);
`ifdef HAZARD_CTRL_DEBUG_EN
            rh = 1'b0;
            rs = 1'b0;
`else
            rh = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
`endif
            lum = rvex && rvdc && (rex[6:0] == 7'h03) && (rex[11:7] != 5'd0) && read_set(rdc)[rex[11:7]];
            brm = rvex && rcp;
            lue = lum && !brm;
            cyc("rand", 0, rdc, rvdc, rex, rvex, rcp, rh, rs,
                {lue, lue, 3'b000}, {brm, brm || lue}, 0);
        end

`ifdef HAZARD_CTRL_DEBUG_EN
        // Halt: four drain cycles with fetch stalled, then frozen.
        cyc("h_req", 0, NOP, 0, NOP, 0, 0, 1, 0, 5'b00000, 2'b00, 0);
        for (int i = 0; i < 4; i++)
            cyc("drain", 0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("halted0", 0, ADD6, 1, LW5, 1, 1, 1, 0, 5'b11111, 2'b00, 1);
        cyc("halted1", 0, NOP, 0, NOP, 0, 0, 1, 1, 5'b11111, 2'b00, 1);
        cyc("step",    0, ADD6, 1, LW5, 1, 0, 1, 0, 5'b11000, 2'b01, 0);
        cyc("re_halt", 0, NOP, 0, NOP, 0, 0, 1, 0, 5'b11111, 2'b00, 1);
        for (int i = 0; i < 2; i++) begin
            cyc("hold_h", 0, NOP, 0, NOP, 0, 0, 1, 1, 5'b11111, 2'b00, 1);
            cyc("hold_s", 0, NOP, 0, NOP, 0, 0, 1, 1, 5'b00000, 2'b00, 0);
        end
        cyc("resume_h", 0, NOP, 0, NOP, 0, 0, 0, 1, 5'b11111, 2'b00, 1);
        cyc("resumed",  0, NOP, 0, NOP, 0, 0, 0, 0, 5'b00000, 2'b00, 0);

        // Load-use in drain extends it by one cycle; branch flush still applies.
        cyc("h2_req", 0, NOP, 0, NOP, 0, 0, 1, 0, 5'b00000, 2'b00, 0);
        cyc("d2_1",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("d2_lu",  0, ADD6, 1, LW5, 1, 0, 1, 0, 5'b11000, 2'b01, 0);
        cyc("d2_br",  0, ADD6, 1, LW5, 1, 1, 1, 0, 5'b10000, 2'b11, 0);
        cyc("d2_4",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("d2_5",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("h2",     0, NOP, 0, NOP, 0, 0, 0, 0, 5'b11111, 2'b00, 1);
        cyc("run2",   0, NOP, 0, NOP, 0, 0, 0, 0, 5'b00000, 2'b00, 0);

        // Dropping the request mid-drain returns to RUN.
        cyc("h3_req", 0, NOP, 0, NOP, 0, 0, 1, 0, 5'b00000, 2'b00, 0);
        cyc("d3_1",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("d3_drop", 0, NOP, 0, NOP, 0, 0, 0, 0, 5'b10000, 2'b00, 0);
        cyc("run3",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b00000, 2'b00, 0);

        // Reset mid-drain.
        cyc("d4_1",   0, NOP, 0, NOP, 0, 0, 1, 0, 5'b10000, 2'b00, 0);
        cyc("d4_rst", 1, NOP, 0, NOP, 0, 0, 1, 0, 5'b00000, 2'b11, 0);
        cyc("run4",   0, ADD6, 1, LW5, 1, 0, 0, 0, 5'b11000, 2'b01, 0);
        cyc("run4b",  0, NOP, 0, NOP, 0, 0, 0, 0, 5'b00000, 2'b00, 0);
`else
        // Debug requests are ignored: no halt, stalls only from load-use.
        for (int i = 0; i < 6; i++)
            cyc("dbg_off", 0, NOP, 0, NOP, 0, 0, 1, 1'(i % 2), 5'b00000, 2'b00, 0);
        cyc("dbg_off_lu", 0, ADD6, 1, LW5, 1, 0, 1, 0, 5'b11000, 2'b01, 0);
        cyc("rst_mid", 1, ADD6, 1, LW5, 1, 0, 1, 0, 5'b00000, 2'b11, 0);
        cyc("post_rst", 0, NOP, 0, NOP, 0, 0, 0, 0, 5'b00000, 2'b00, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It drives the per-stage stall inputs (`s_fe`..`s_wb`) and inserts bubbles into the decode and execute stages. It handles three things: load-use hazards, taken-branch flushes, and a debug halt/single-step sequence. It sits beside the stage chain: it reads the decode- and execute-stage instruction registers and the branch-compare result, and feeds stall and flush controls back to the stages.

## Interface
- `DRAIN_CYCLES`, default 4: cycles spent draining in-flight instructions after a halt request.
- `STALL_CNT_W`, default 16: width of the stall performance counter.

- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `IR_dc` in 32: instruction currently in decode.
- `v_dc` in 1: `IR_dc` valid.
- `IR_ex` in 32: instruction currently in execute.
- `v_ex` in 1: `IR_ex` valid.
- `CP_ex` in 1: branch/jump taken in execute.
- `halt_req` in 1: level; debugger requests halt.
- `step_req` in 1: pulse; advance a halted pipeline one clock.
- `s_fe`, `s_dc`, `s_ex`, `s_me`, `s_wb` out 1 each: stage stalls.
- `fl_dc`, `fl_ex` out 1 each: stage output replaced by bubble (valid cleared).
- `halted` out 1: pipeline frozen.
- `stall_cnt` out `STALL_CNT_W`: cycles with any stall asserted.

## Operation
- **Load-use hazard (`lu`).** All of the following hold:
  - `v_ex`, `v_dc`.
  - `IR_ex[6:0]` is LOAD (0000011) with rd ≠ x0.
  - rd equals a source register that `IR_dc` actually reads:
    - rs1 for R, I, LOAD, STORE, BRANCH, JALR.
    - rs2 for R, STORE, BRANCH.
  - Result: `s_fe` = `s_dc` = 1 and `fl_ex` = 1 for that cycle.
- **Taken branch (`br`)** = `v_ex` & `CP_ex`.
  - Result: `fl_dc` = `fl_ex` = 1; no stalls.
  - `br` suppresses `lu`.
- **FSM states:** RUN, DRAIN, HALTED, STEP.
  - RUN: only hazard logic is active. `halt_req` moves to DRAIN and loads the drain counter with `DRAIN_CYCLES`−1.
  - DRAIN:
    - `s_fe` = 1.
    - Counter decrements on each cycle without `lu`; at 0 the next state is HALTED.
    - Deassertion of `halt_req` returns to RUN.
    - `br` flushes still apply.
  - HALTED: all `s_*` = 1, `halted` = 1, `fl_*` = 0.
    - `halt_req` low → RUN. This takes priority over `step_req`.
    - `step_req` → STEP.
  - STEP: behaves as RUN for exactly one cycle (hazard logic active), then returns to HALTED.
- **`stall_cnt`:** increments when any `s_*` = 1, saturates at all-ones, and is not cleared by the FSM.
- **Reset:**
  - State RUN, drain counter 0, `stall_cnt` 0, `halted` 0.
  - While `rst` = 1: all `s_*` = 0 and `fl_dc` = `fl_ex` = 1, so the pipeline clears.

## Timing
- Stall and flush outputs are combinational from the registered state plus the current `IR_*`, `v_*` and `CP_ex`. They act in the same cycle the hazard is visible.
- FSM, counters and `halted` are registered; `halted` rises the cycle the state becomes HALTED.
- Load-use costs exactly one bubble. After one stall cycle the load has moved to memory, so `lu` deasserts.
- Halt latency from `halt_req` to `halted` is `DRAIN_CYCLES`+1 cycles, plus one per `lu` cycle during DRAIN.
- `step_req` held high re-enters STEP every other cycle (HALTED→STEP→HALTED).
- `rst` asserted mid-DRAIN or in HALTED returns to RUN on the next edge.

## Configuration
- `HAZARD_CTRL_DEBUG_EN` defined: the halt/step FSM, `halt_req`, `step_req` and `halted` are implemented as above.
- Not defined:
  - The state is fixed at RUN and `halted` is tied to 0.
  - `halt_req` and `step_req` remain ports but are ignored.
  - Stalls come only from `lu`.

## Structure
- Opcode constants (LOAD, STORE, BRANCH, JALR, OP, OP_IMM) and the FSM state encodings go in shared `definitions.v`.
- One sub-module, `hazard_detect`: combinational; inputs `IR_dc`, `v_dc`, `IR_ex`, `v_ex`, `CP_ex`; outputs `lu` and `br`.
- The top level holds the FSM, drain counter and `stall_cnt`.

## Test plan
- **Load-use:** `IR_ex` = `lw x5,0(x1)`, `IR_dc` = `add x6,x5,x2`, both valid → one cycle `s_fe` = `s_dc` = `fl_ex` = 1, then 0; `stall_cnt` = 1.
- **No hazard:** `IR_dc` = `lui x5,1` after the same load → no stall (LUI reads no registers). A load to x0 also gives no stall.
- **Branch priority:** `CP_ex` = 1 with a coincident load-use pattern → `fl_dc` = `fl_ex` = 1, `s_dc` = 0.
- **Halt:** assert `halt_req` with `DRAIN_CYCLES` = 4 → `s_fe` high for 4 cycles, `halted` = 1 on the 5th, all `s_*` = 1.
- **Step/resume:** pulse `step_req` while halted → exactly one cycle of `s_*` = 0, then frozen. Drop `halt_req` → RUN next cycle.
- **Reset mid-DRAIN:** `rst` pulse in DRAIN → RUN, `stall_cnt` = 0, `fl_*` = 1 while `rst` is high.
